tdd_frame_sched: RTL and testbench

- Time-division duplex frame scheduler for the AD9361 sample path.
- Counts sample strobes through a programmable frame and opens TX and RX windows inside it.
- Its TX/RX window outputs gate the stream enables into the AXI-to-stream mover; it also drives the AD9361 TXNRX, PA enable and RF switch pins.
- Configured from the register space: frame length, window bounds, one-shot frame-length adjust for timing alignment.

---
 rtl/tdd_frame_sched_if.sv | 35 +++
 rtl/tdd_frame_sched.sv | 152 +++++++++++++++
 tb/tb_tdd_frame_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdd_frame_sched_if.sv
// Configuration/status bundle between the register space and the TDD frame scheduler.
// The master side drives strobe and configuration; the slave side (scheduler) drives status and RF controls.
interface tdd_frame_sched_if #(
    parameter int CNT_W = 24,
    parameter int ADJ_W = 16
);
    logic                    ce;
    logic                    enable;
    logic [CNT_W-1:0]        frame_len;
    logic [CNT_W-1:0]        tstart;
    logic [CNT_W-1:0]        tend;
    logic [CNT_W-1:0]        rstart;
    logic [CNT_W-1:0]        rend;
    logic signed [ADJ_W-1:0] adj_val;
    logic                    adj_req;
    logic                    adj_pending;
    logic [CNT_W-1:0]        frame_cnt;
    logic [31:0]             frame_num;
    logic                    sync;
    logic                    tx_en;
    logic                    rx_en;
    logic                    tx_rx;
    logic                    pa_en;
    logic                    rf_sw;

    modport master (
        output ce, enable, frame_len, tstart, tend, rstart, rend, adj_val, adj_req,
        input  adj_pending, frame_cnt, frame_num, sync, tx_en, rx_en, tx_rx, pa_en, rf_sw
    );

    modport slave (
        input  ce, enable, frame_len, tstart, tend, rstart, rend, adj_val, adj_req,
        output adj_pending, frame_cnt, frame_num, sync, tx_en, rx_en, tx_rx, pa_en, rf_sw
    );
endinterface

// File: rtl/tdd_frame_sched.sv
// TDD frame scheduler: counts sample strobes through a programmable frame and opens
// TX/RX windows (registered, aligned with frame_cnt) plus the AD9361 TXNRX/PA/RF switch pins.
module tdd_frame_sched #(
    parameter int CNT_W = 24,
    parameter int ADJ_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tdd_frame_sched_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam int LW = CNT_W + 2;
    localparam logic signed [LW-1:0] ONE     = LW'(1);
    localparam logic signed [LW-1:0] LEN_MAX = {2'b01, {CNT_W{1'b0}}};

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             num_q, num_d;
    logic                    sync_q, sync_d;
    logic                    tx_q, tx_d;
    logic                    rx_q, rx_d;
    logic                    pend_q, pend_d;
    logic signed [ADJ_W-1:0] adj_q, adj_d;
    logic signed [ADJ_W-1:0] adj_cur_q, adj_cur_d;

    logic signed [LW-1:0]    len_base, len_sum, len_eff;
    logic [LW-1:0]           last_pos;
    logic                    wrap;
    logic                    pos_upd;

    function automatic logic in_win(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] e,
                                    input logic [CNT_W-1:0] p);
        logic hit;
        hit = 1'b0;
        if (s < e)      hit = (p >= s) && (p < e);
        else if (s > e) hit = (p >= s) || (p < e);
        return hit;
    endfunction

    // Effective frame length: live frame_len plus the adjust owned by the current frame, clamped.
    always_comb begin
        len_base = $signed({2'b00, bus.frame_len});
        if (bus.frame_len == '0) len_base = ONE;
        len_sum = len_base + $signed({{(LW-ADJ_W){adj_cur_q[ADJ_W-1]}}, adj_cur_q});
        if (len_sum < ONE)          len_eff = ONE;
        else if (len_sum > LEN_MAX) len_eff = LEN_MAX;
        else                        len_eff = len_sum;
        last_pos = len_eff - ONE;
    end

    assign wrap = {2'b00, cnt_q} >= last_pos;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        sync_d    = 1'b0;
        tx_d      = tx_q;
        rx_d      = rx_q;
        pend_d    = pend_q;
        adj_d     = adj_q;
        adj_cur_d = adj_cur_q;
        pos_upd   = 1'b0;

        if (bus.adj_req && !pend_q) begin
            pend_d = 1'b1;
            adj_d  = bus.adj_val;
        end

        case (state_q)
            IDLE: begin
                if (bus.enable && bus.ce) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    sync_d    = 1'b1;
                    adj_cur_d = '0;
                    pos_upd   = 1'b1;
                end
            end
            RUN: begin
                if (bus.ce) begin
                    pos_upd = 1'b1;
                    if (wrap) begin
                        cnt_d     = '0;
                        sync_d    = 1'b1;
                        num_d     = num_q + 32'd1;
                        // A pending adjust belongs to exactly the frame starting at this wrap.
                        adj_cur_d = pend_q ? adj_q : '0;
                        if (pend_q) pend_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Windows are decoded from the next position so they line up with the registered frame_cnt.
        if (pos_upd) begin
            tx_d = in_win(bus.tstart, bus.tend, cnt_d);
            rx_d = in_win(bus.rstart, bus.rend, cnt_d) && !tx_d;
        end

        if (!bus.enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            sync_d    = 1'b0;
            tx_d      = 1'b0;
            rx_d      = 1'b0;
            pend_d    = 1'b0;
            adj_cur_d = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every register, including the latched adjust, is cleared so no stale value survives reset.
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            sync_q    <= 1'b0;
            tx_q      <= 1'b0;
            rx_q      <= 1'b0;
            pend_q    <= 1'b0;
            adj_q     <= '0;
            adj_cur_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            sync_q    <= sync_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            pend_q    <= pend_d;
            adj_q     <= adj_d;
            adj_cur_q <= adj_cur_d;
        end
    end

    assign bus.adj_pending = pend_q;
    assign bus.frame_cnt   = cnt_q;
    assign bus.frame_num   = num_q;
    assign bus.sync        = sync_q;
    assign bus.tx_en       = tx_q;
    assign bus.rx_en       = rx_q;
    assign bus.tx_rx       = tx_q;
    assign bus.pa_en       = tx_q;
    assign bus.rf_sw       = tx_q;
endmodule

// File: tb/tb_tdd_frame_sched.sv
// Directed bench for tdd_frame_sched: a cycle model pushes expected outputs to a scoreboard
// each cycle, plus directed frame-period and disable/reset checks.
module tb_tdd_frame_sched;
    typedef struct packed {
        logic        pend;
        logic [23:0] cnt;
        logic [31:0] num;
        logic        sync;
        logic        tx;
        logic        rx;
        logic        txrx;
        logic        pa;
        logic        rf;
    } exp_t;

    logic clk;
    logic rst_n;

    tdd_frame_sched_if #(.CNT_W(24), .ADJ_W(16)) bus ();

    tdd_frame_sched #(.CNT_W(24), .ADJ_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t sb[$];

    // stimulus state
    logic               ce_v, en_v, req_v, stall;
    int                 phase;
    logic [23:0]        fl_v, ts_v, te_v, rs_v, re_v;
    logic signed [15:0] adj_v;

    // model state
    logic        m_run, m_sync, m_tx, m_rx, m_pend;
    int          m_pos, m_adj, m_cur;
    logic [31:0] m_num;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic win(input int s, input int e, input int p);
        if (s == e) return 1'b0;
        if (s < e)  return (p >= s && p < e);
        return !(p >= e && p < s);
    endfunction

    task automatic model_eval(input logic ce_now);
        int fl, len;
        if (!rst_n) begin
            m_run = 0; m_pos = 0; m_num = 0; m_sync = 0; m_tx = 0; m_rx = 0;
            m_pend = 0; m_adj = 0; m_cur = 0;
        end else if (!en_v) begin
            m_run = 0; m_pos = 0; m_sync = 0; m_tx = 0; m_rx = 0; m_pend = 0; m_cur = 0;
        end else begin
            logic old_pend;
            old_pend = m_pend;
            if (req_v && !old_pend) begin
                m_pend = 1;
                m_adj  = int'(adj_v);
            end
            m_sync = 0;
            if (!m_run) begin
                if (ce_now) begin
                    m_run = 1; m_pos = 0; m_sync = 1; m_cur = 0;
                    m_tx = win(ts_v, te_v, 0);
                    m_rx = win(rs_v, re_v, 0) && !m_tx;
                end
            end else if (ce_now) begin
                fl  = (fl_v == 0) ? 1 : int'(fl_v);
                len = fl + m_cur;
                if (len < 1) len = 1;
                if (m_pos >= len - 1) begin
                    m_pos = 0; m_sync = 1; m_num = m_num + 1;
                    m_cur = old_pend ? m_adj : 0;
                    if (old_pend) m_pend = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
                m_tx = win(ts_v, te_v, m_pos);
                m_rx = win(rs_v, re_v, m_pos) && !m_tx;
            end
        end
    endtask

    task automatic step();
        logic ce_now;
        exp_t e, got;
        @(negedge clk);
        ce_now = stall ? (phase == 0) : ce_v;
        if (stall) phase = (phase + 1) % 3;
        bus.ce = ce_now; bus.enable = en_v; bus.adj_req = req_v; bus.adj_val = adj_v;
        bus.frame_len = fl_v; bus.tstart = ts_v; bus.tend = te_v;
        bus.rstart = rs_v; bus.rend = re_v;
        model_eval(ce_now);
        e = '{pend: m_pend, cnt: 24'(m_pos), num: m_num, sync: m_sync,
              tx: m_tx, rx: m_rx, txrx: m_tx, pa: m_tx, rf: m_tx};
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = '{pend: bus.adj_pending, cnt: bus.frame_cnt, num: bus.frame_num, sync: bus.sync,
                tx: bus.tx_en, rx: bus.rx_en, txrx: bus.tx_rx, pa: bus.pa_en, rf: bus.rf_sw};
        e = sb.pop_front();
        check("scoreboard", 64'(got), 64'(e));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_adj(input logic signed [15:0] v);
        adj_v = v; req_v = 1'b1;
        step();
        req_v = 1'b0;
    endtask

    // Steps until the DUT shows sync; n is the number of cycles taken.
    task automatic next_sync(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.sync !== 1'b1 && n < 200);
        check("sync_arrived", 64'(bus.sync), 64'(1));
    endtask

    task automatic run_to(input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (int'(bus.frame_cnt) != p && n < 200);
        check("run_to_pos", 64'(bus.frame_cnt), 64'(p));
    endtask

    initial begin
        int n;
        logic [31:0] saved;
        ce_v = 1; en_v = 0; req_v = 0; stall = 0; phase = 0; adj_v = 0;
        fl_v = 10; ts_v = 2; te_v = 5; rs_v = 6; re_v = 9;
        rst_n = 0;
        steps(3);
        check("reset_cnt", 64'(bus.frame_cnt), 64'(0));
        check("reset_num", 64'(bus.frame_num), 64'(0));
        rst_n = 1;
        steps(2);
        check("idle_cnt", 64'(bus.frame_cnt), 64'(0));

        // nominal frame
        en_v = 1;
        step();
        check("entry_sync", 64'(bus.sync), 64'(1));
        check("entry_cnt", 64'(bus.frame_cnt), 64'(0));
        next_sync(n); check("period_nominal_a", 64'(n), 64'(10));
        next_sync(n); check("period_nominal_b", 64'(n), 64'(10));
        check("frame_num_2", 64'(bus.frame_num), 64'(2));
        run_to(3);
        check("tx_pos3", 64'({bus.tx_en, bus.tx_rx, bus.pa_en, bus.rf_sw}), 64'(4'hF));
        run_to(7);
        check("rx_pos7", 64'({bus.tx_en, bus.rx_en}), 64'(2'b01));

        // wrap-around TX window over an overlapping RX window
        ts_v = 8; te_v = 2; rs_v = 0; re_v = 4;
        steps(25);
        run_to(0);
        check("wrap_tx_pos0", 64'({bus.tx_en, bus.rx_en}), 64'(2'b10));
        run_to(2);
        check("wrap_rx_pos2", 64'({bus.tx_en, bus.rx_en}), 64'(2'b01));

        // one-shot adjust -3
        ts_v = 2; te_v = 5; rs_v = 6; re_v = 9;
        run_to(5);
        pulse_adj(-16'sd3);
        check("adj_pending_set", 64'(bus.adj_pending), 64'(1));
        next_sync(n);
        check("adj_pending_clr", 64'(bus.adj_pending), 64'(0));
        next_sync(n); check("period_adj_m3", 64'(n), 64'(7));
        next_sync(n); check("period_after_m3", 64'(n), 64'(10));

        // adjust +5 with a second request ignored
        pulse_adj(16'sd5);
        pulse_adj(-16'sd2);
        check("adj_still_pending", 64'(bus.adj_pending), 64'(1));
        next_sync(n);
        next_sync(n); check("period_adj_p5", 64'(n), 64'(15));
        next_sync(n); check("period_after_p5", 64'(n), 64'(10));

        // ce stall 1 in 3
        stall = 1; phase = 0;
        next_sync(n);
        next_sync(n); check("period_stall_a", 64'(n), 64'(30));
        step();
        check("sync_one_wide", 64'(bus.sync), 64'(0));
        next_sync(n); check("period_stall_b", 64'(n), 64'(29));
        stall = 0;

        // disable mid-frame with tx active and an adjust pending
        next_sync(n);
        pulse_adj(16'sd4);
        run_to(4);
        check("tx_before_disable", 64'(bus.tx_en), 64'(1));
        saved = bus.frame_num;
        en_v = 0;
        step();
        check("dis_outputs", 64'({bus.tx_en, bus.rx_en, bus.tx_rx, bus.pa_en, bus.rf_sw, bus.sync}), 64'(0));
        check("dis_cnt", 64'(bus.frame_cnt), 64'(0));
        check("dis_pending", 64'(bus.adj_pending), 64'(0));
        check("dis_num_held", 64'(bus.frame_num), 64'(saved));
        steps(2);
        en_v = 1;
        step();
        check("reen_sync", 64'({bus.sync, bus.frame_cnt}), 64'({1'b1, 24'd0}));
        next_sync(n); check("period_reen", 64'(n), 64'(10));

        // reset mid-frame
        run_to(3);
        rst_n = 0;
        step();
        check("rst_all", 64'({bus.frame_num, bus.frame_cnt, bus.tx_en, bus.rx_en, bus.sync, bus.adj_pending}), 64'(0));
        rst_n = 1;
        steps(3);

        // degenerate frame length 0
        fl_v = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("fl0_sync", 64'({bus.sync, bus.frame_cnt}), 64'({1'b1, 24'd0}));
        end

        // adjust clamped to length 1
        fl_v = 10;
        next_sync(n);
        pulse_adj(-16'sd20);
        next_sync(n);
        next_sync(n); check("period_clamp", 64'(n), 64'(1));
        next_sync(n); check("period_after_clamp", 64'(n), 64'(10));

        // empty TX window
        ts_v = 3; te_v = 3;
        for (int i = 0; i < 22; i++) begin
            step();
            check("empty_tx", 64'(bus.tx_en), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
